// File: rtl/rf_ctrl_pkg.sv
// Shared constants for the integer register-file write-back controller.
// No logic and no latency. Nothing here exerts backpressure.
// Holds the register count, the default requester count and the requester slot numbers.
package rf_ctrl_pkg;

    localparam int RF_WORDS     = 32;
    localparam int NREQ_DEFAULT = 3;

    // Fixed requester slots on the write-back arbiter
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after rr_ptr, wrapping.
// Grant is combinational from req. rr_ptr moves past the winner on the clock edge where advance is high.
// With advance low the pointer holds, so an unaccepted grant keeps its priority.
// Ports: clk, rst (sync, active-high), req[N], advance, gnt[N] (one-hot or zero).
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gidx;
    logic          found;

    // (a + b) mod N, valid for a < N and 0 <= b <= N
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N) begin
            s = s - N;
        end
        return s[PW-1:0];
    endfunction

    always_comb begin
        gnt   = '0;
        gidx  = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[wrap_add(rr_ptr, i)]) begin
                gnt[wrap_add(rr_ptr, i)] = 1'b1;
                gidx                     = wrap_add(rr_ptr, i);
                found                    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance && found) begin
            rr_ptr <= wrap_add(gidx, 1);
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: round-robin among execute-unit requesters, plus a busy scoreboard for issue hazards.
// Latency: the grant is combinational in cycle N. o_rf_* are registered and valid in N+1, and the busy bit clears on the edge that ends N+1.
// Backpressure: the write port never stalls, so one request is granted per cycle. o_issue_stall holds issue on RAW/WAW hazards.
// Ports: clk, rst; i_wb_valid/addr/data -> o_wb_ready; i_issue_valid/rd/rs1/rs2/has_rd -> o_issue_stall;
//        i_flush; o_rf_wen/o_rf_waddr/o_rf_wdata. Requester buses are packed flat, with requester g at slice g.
module rf_wb_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int DLEN = 32,
    parameter int ALEN = 5,
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_wb_valid,
    input  logic [NREQ*ALEN-1:0] i_wb_addr,
    input  logic [NREQ*DLEN-1:0] i_wb_data,
    output logic [NREQ-1:0]      o_wb_ready,
    input  logic                 i_issue_valid,
    input  logic [ALEN-1:0]      i_issue_rd,
    input  logic [ALEN-1:0]      i_issue_rs1,
    input  logic [ALEN-1:0]      i_issue_rs2,
    input  logic                 i_issue_has_rd,
    output logic                 o_issue_stall,
    input  logic                 i_flush,
    output logic                 o_rf_wen,
    output logic [ALEN-1:0]      o_rf_waddr,
    output logic [DLEN-1:0]      o_rf_wdata
);

    logic [NREQ-1:0]     gnt;
    logic                any_gnt;
    logic [ALEN-1:0]     sel_addr;
    logic [DLEN-1:0]     sel_data;
    logic [RF_WORDS-1:0] busy;
    logic [RF_WORDS-1:0] busy_nxt;
    logic                issue_set;

    // The write port always accepts, so every grant is a transfer.
    assign any_gnt    = |gnt;
    assign o_wb_ready = gnt;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (i_wb_valid),
        .advance (any_gnt),
        .gnt     (gnt)
    );

    // gnt is one-hot, so OR-ing the masked slices selects the winner
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | i_wb_addr[i*ALEN +: ALEN];
                sel_data = sel_data | i_wb_data[i*DLEN +: DLEN];
            end
        end
    end

    // A grant to x0 is consumed, but the write strobe is never raised for it
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rf_wen   <= 1'b0;
            o_rf_waddr <= '0;
            o_rf_wdata <= '0;
        end else if (any_gnt) begin
            o_rf_wen   <= (sel_addr != '0);
            o_rf_waddr <= sel_addr;
            o_rf_wdata <= sel_data;
        end else begin
            o_rf_wen   <= 1'b0;
        end
    end

    assign o_issue_stall = i_issue_valid &
                           (busy[i_issue_rs1] | busy[i_issue_rs2] |
                            (i_issue_has_rd & busy[i_issue_rd]));

    assign issue_set = i_issue_valid & ~o_issue_stall & i_issue_has_rd &
                       (i_issue_rd != '0);

    // The clear is applied before the set, so a new issue to the same register wins.
    // A flush wipes everything but leaves the in-flight write alone.
    always_comb begin
        busy_nxt = busy;
        if (o_rf_wen) begin
            busy_nxt[o_rf_waddr] = 1'b0;
        end
        if (issue_set) begin
            busy_nxt[i_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
        if (i_flush) begin
            busy_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Write-back controller for the integer register file's single write port. It arbitrates round-robin between NREQ write-back requesters (ALU, LSU, MDU) and registers the winning write onto the register-file write port. It also keeps a pending-write scoreboard that stalls instruction issue on RAW/WAW hazards against writes not yet committed. It sits between the execute units and the 2-read/1-write register file.

## Interface
- DLEN, 32, data width
- ALEN, 5, register address width (32 registers)
- NREQ, 3, number of write-back requesters
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_wb_valid  in  NREQ  per-requester write-back request
- i_wb_addr  in  NREQ x ALEN  destination register per requester
- i_wb_data  in  NREQ x DLEN  write data per requester
- o_wb_ready  out  NREQ  grant, one-hot or zero, combinational
- i_issue_valid  in  1  issue stage presents an instruction
- i_issue_rd / i_issue_rs1 / i_issue_rs2  in  ALEN each  destination and sources
- i_issue_has_rd  in  1  instruction writes rd
- o_issue_stall  out  1  hazard, issue must hold, combinational
- i_flush  in  1  clear scoreboard
- o_rf_wen / o_rf_waddr / o_rf_wdata  out  1 / ALEN / DLEN  register-file write port, registered

## Operation
- **Arbitration**
  - Round-robin pointer `rr_ptr`.
  - The grant goes to the first valid requester at or after `rr_ptr`, wrapping modulo NREQ.
  - `o_wb_ready[g]=1` only for the granted requester. All ready outputs are 0 when no requester is valid.
  - A transfer occurs when `valid & ready`. On a transfer, `rr_ptr <= (g+1) mod NREQ`. With no transfer, `rr_ptr` holds.
  - The register-file port never back-pressures, so one grant is issued every cycle while any request is valid.
- **Output stage**
  - On a grant, it captures addr/data and sets `o_rf_wen`.
  - With no grant, `o_rf_wen <= 0`; addr/data hold.
  - A write to x0 is granted and consumed normally, but `o_rf_wen` is forced to 0 for it.
- **Scoreboard**
  - `busy[0..31]`; `busy[0]` is constantly 0.
  - `o_issue_stall = i_issue_valid & (busy[rs1] | busy[rs2] | (i_issue_has_rd & busy[rd]))`.
  - Set: when `i_issue_valid & ~o_issue_stall & i_issue_has_rd & rd!=0`, `busy[rd] <= 1`.
  - Clear: when `o_rf_wen`, `busy[o_rf_waddr] <= 0`. This is the same edge on which the register file writes.
  - Set and clear on the same register in the same cycle: the set wins.
  - `i_flush`: all busy bits go to 0; it overrides set and clear in that cycle. The arbiter pointer and the output stage are unaffected, so an in-flight write still commits.
- Write-back to a register that is not busy is legal; no check is made.

## Timing
- Reset values: `o_rf_wen=0`, `o_rf_waddr=0`, `o_rf_wdata=0`, `rr_ptr=0`, all busy bits 0. With no inputs, `o_wb_ready=0` and `o_issue_stall=0`.
- `rst` asserted mid-operation discards the output-stage write. `o_rf_wen` is 0 in the cycle after reset.
- Latency:
  - Grant in cycle N.
  - `o_rf_*` valid in N+1; register file updated at the end of N+1.
  - Busy bit cleared at that same edge; a dependent instruction issues in N+2.
- Issue in cycle M sets busy from cycle M+1. A dependent instruction in M+1 stalls.
- Throughput: one write per cycle, sustained.
- Starvation bound: a continuously valid requester is granted within NREQ cycles.

## Structure
- Package `rf_ctrl_pkg` holds:
  - `RF_WORDS=32`
  - default `NREQ`
  - requester index constants `REQ_ALU=0`, `REQ_LSU=1`, `REQ_MDU=2`
- Sub-module `rr_arbiter` (parameter N; ports `req`, `gnt` one-hot, `advance`; owns `rr_ptr`) is instantiated once.
- Scoreboard and output stage stay in the top level.

## Test plan
- Reset: hold `rst` 2 cycles, then drive nothing → all outputs 0. Issue rs1=3, rs2=4, rd=5 → `o_issue_stall=0`.
- Round-robin: ALU/LSU/MDU all valid from cycle N with addrs 1/2/3, data 0xA/0xB/0xC.
  - Grants are 0,1,2 in N..N+2.
  - `o_rf_wen` is high N+1..N+3 with waddr 1,2,3.
  - The pointer then returns to 0.
- RAW hazard:
  - Issue rd=5 at cycle 0. Issue rs1=5 at cycle 1 → stall.
  - LSU write-back to 5 granted at cycle 3 → `o_rf_wen` in cycle 4, stall low in cycle 5.
- x0 write: ALU valid with addr 0, data 0xFFFF_FFFF → `o_wb_ready=1`, `o_rf_wen=0` the next cycle, no busy change.
- Same-edge set/clear on reg 7: committing write to 7 and new issue rd=7 in the same cycle → `busy[7]=1` afterwards, so rs1=7 stalls.
- Flush and mid-op reset:
  - `i_flush` with busy{5,9} → no stall the next cycle; an in-flight write still commits.
  - `rst` pulsed the cycle after a grant → `o_rf_wen=0`.
